booth_r4_seq_mult_ctrl: RTL and testbench
=========================================

Name: booth_r4_seq_mult_ctrl

Overview:
- Iterative radix-4 Booth multiplier controller and datapath sequencer.
- Accepts one signed operand pair per transaction over a valid/ready handshake.
- Recodes multiplier B into overlapping 3-bit Booth digits, one digit per cycle, and accumulates the selected partial product (0, ±A, ±2A) into a shifting accumulator.
- Serves area-constrained arithmetic paths where a full parallel Booth array with per-row sign-bit generation is too costly; trades latency for area.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise).
- NDIG, WIDTH/2, localparam; Booth digits per signed operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept an operand pair
- in_a  input  WIDTH  multiplicand, two's complement
- in_b  input  WIDTH  multiplier, two's complement
- out_valid  output  1  product available
- out_ready  input  1  consumer accepts product
- out_p  output  2*WIDTH  product, two's complement
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset values (next clk edge with rst=1):
  - state=IDLE, in_ready=1, out_valid=0, out_p=0, busy=0.
  - Accumulator, multiplicand and multiplier registers, and digit counter all cleared.
- rst overrides every other input in all states; an in-flight operation is discarded and no output is produced.
- States: IDLE, RUN, DONE (enum in package).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - Capture in_a sign-extended to 2*WIDTH into mcand.
    - Capture {in_b,1'b0} into mplier (WIDTH+1 bits).
    - acc=0, cnt=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, recode mplier[2:0] into a digit:
    - 000/111 -> 0
    - 001/010 -> +A
    - 011 -> +2A
    - 100 -> -2A
    - 101/110 -> -A
  - Datapath update each cycle:
    - acc += selected value; -A is formed as ~mcand + 1 (the sign-generation term), -2A as ~(mcand<<1) + 1.
    - mcand <<= 2.
    - mplier arithmetic >>= 2.
    - cnt++.
  - When cnt==NDIG-1 (last digit added this cycle), go to DONE.
  - All arithmetic is modulo 2^(2*WIDTH); no overflow is possible for in-range operands.
- DONE:
  - out_valid=1, out_p=acc, held stable until out_valid&&out_ready.
  - On handshake, go to IDLE; out_valid drops the next cycle.
  - No new operand is accepted in DONE; there is no overlap between transactions.
- Latency: out_valid rises NDIG+1 cycles after the accepting edge (WIDTH=8 -> 5 cycles).
- Throughput: one product per NDIG+2 cycles with out_ready tied high.
- Back-to-back: in_valid held continuously is accepted again in the IDLE cycle that follows the output handshake.
- in_a/in_b are don't-care outside the accepting cycle.
- out_p retains its last value in IDLE; only out_valid qualifies it.

Optional Feature:
- Macro: BOOTH_SEQ_UNSIGNED_EN.
- Defined:
  - Adds input port in_signed (1 bit), sampled with the operands.
  - in_signed=0: operands are zero-extended to WIDTH+2 bits, and NDIG_U=NDIG+1 digits are processed (one extra RUN cycle, latency NDIG+2).
  - in_signed=1: behaviour identical to the signed path above.
  - Product remains 2*WIDTH bits (unsigned result fits exactly).
- Undefined: port absent, signed-only operation; RTL identical to the description above.

Decomposition:
- Package booth_seq_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - booth_dig_t struct {zero, two, neg}.
  - Function for the NDIG calculation.
- Sub-module booth_r4_digit: combinational; 3-bit window in, booth_dig_t out. Unit-testable against the digit table above.
- Controller, accumulator and shift registers live in booth_r4_seq_mult_ctrl.

Test Plan:
1. Reset mid-RUN:
   - Stimulus: accept 5*3, assert rst for 1 cycle at cycle 2.
   - Required: out_valid=0, out_p=0, in_ready=1 next cycle; no product is ever emitted for that transaction.
2. Corner products (WIDTH=8):
   - -128*-128 -> 0x4000.
   - 127*-128 -> 0xC080.
   - 0*-77 -> 0x0000.
   - -1*-1 -> 0x0001.
   - Each product appears exactly 5 cycles after acceptance.
3. Backpressure:
   - Stimulus: 7*-6 with out_ready=0 for 10 cycles.
   - Required: out_valid stays 1 and out_p stays 0xFFD6 throughout; in_ready stays 0; single handshake on release.
4. Streaming:
   - Stimulus: in_valid held high, out_ready=1, 20 random pairs.
   - Required: one accept every 6 cycles; every product matches the signed reference model.
5. Unsigned (with BOOTH_SEQ_UNSIGNED_EN):
   - 255*255, in_signed=0 -> 0xFE01 after 6 cycles.
   - Same operands with in_signed=1 -> 0x0001 after 5 cycles.
6. Exhaustive (WIDTH=4): all 256 signed pairs back-to-back; each result equals a*b.

Source files
------------

// File: rtl/booth_seq_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier:
// FSM state encoding, recoded digit bundle, digit-count helper.
package booth_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // zero: digit is 0; two: magnitude 2A; neg: subtract.
    typedef struct packed {
        logic zero;
        logic two;
        logic neg;
    } booth_dig_t;

    function automatic int booth_ndig(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth recoder: 3-bit multiplier window -> digit.
// Ports: win (3-bit window, LSB is the overlap bit), dig (recoded digit).
module booth_r4_digit
    import booth_seq_pkg::*;
(
    input  logic [2:0] win,
    output booth_dig_t dig
);

    always_comb begin
        dig = '0;
        case (win)
            3'b000, 3'b111: dig.zero = 1'b1;
            3'b001, 3'b010: dig.zero = 1'b0;
            3'b011:         dig.two  = 1'b1;
            3'b100: begin
                dig.two = 1'b1;
                dig.neg = 1'b1;
            end
            default:        dig.neg  = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult_ctrl.sv
// Iterative radix-4 Booth multiplier: one digit per cycle into a
// shifting accumulator, valid/ready handshake on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b
// operand side; out_valid/out_ready/out_p product side; busy in RUN/DONE.
// Optional BOOTH_SEQ_UNSIGNED_EN adds in_signed for unsigned operands.
module booth_r4_seq_mult_ctrl
    import booth_seq_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
`ifdef BOOTH_SEQ_UNSIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int NDIG = booth_ndig(WIDTH);
    localparam int PW   = 2 * WIDTH;
`ifdef BOOTH_SEQ_UNSIGNED_EN
    // Two extra zero bits let an unsigned MSB be recoded correctly.
    localparam int MW   = WIDTH + 3;
`else
    localparam int MW   = WIDTH + 1;
`endif
    localparam int CW   = $clog2(NDIG + 2);
    localparam logic [CW-1:0] LAST_S = CW'(NDIG - 1);

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_chk
        $error("booth_r4_seq_mult_ctrl: WIDTH must be even and >= 4");
    end

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [MW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   last;
    logic            accept;
    logic            step;
    logic            a_ext;
    logic            b_ext;
    booth_dig_t      dig;
    logic [PW-1:0]   mag;
    logic [PW-1:0]   pp;

`ifdef BOOTH_SEQ_UNSIGNED_EN
    localparam logic [CW-1:0] LAST_U = CW'(NDIG);
    logic sgn;

    assign a_ext = in_signed & in_a[WIDTH-1];
    assign b_ext = in_signed & in_b[WIDTH-1];
    assign last  = sgn ? LAST_S : LAST_U;
`else
    assign a_ext = in_a[WIDTH-1];
    assign b_ext = in_b[WIDTH-1];
    assign last  = LAST_S;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    booth_r4_digit u_digit (
        .win (mplier[2:0]),
        .dig (dig)
    );

    // Partial product: magnitude A or 2A, negated by invert-plus-one.
    always_comb begin
        mag = dig.two ? (mcand << 1) : mcand;
        pp  = '0;
        if (!dig.zero) begin
            pp = dig.neg ? (~mag + PW'(1)) : mag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`ifdef BOOTH_SEQ_UNSIGNED_EN
            sgn    <= 1'b0;
`endif
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{a_ext}}, in_a};
            mplier <= {{(MW-WIDTH-1){b_ext}}, in_b, 1'b0};
            cnt    <= '0;
`ifdef BOOTH_SEQ_UNSIGNED_EN
            sgn    <= in_signed;
`endif
        end else if (step) begin
            acc    <= acc + pp;
            mcand  <= mcand << 2;
            mplier <= {{2{mplier[MW-1]}}, mplier[MW-1:2]};
            cnt    <= cnt + CW'(1);
        end
    end

    // Product is the accumulator; out_valid alone qualifies it.
    assign out_p = acc;

endmodule

// File: tb/tb_booth_r4_seq_mult_ctrl.sv
// Self-checking bench for booth_r4_seq_mult_ctrl (WIDTH=8 and WIDTH=4).
// Products are compared against plain integer multiplication.
module tb_booth_r4_seq_mult_ctrl;

    localparam int W    = 8;
    localparam int W4   = 4;
    localparam int NDIG = W / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  in_a, in_b;
    logic [2*W-1:0] out_p;
    logic          in_signed;

    logic          v4, r4, ov4, or4, busy4;
    logic [W4-1:0] a4, b4;
    logic [2*W4-1:0] p4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mult_ctrl #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef BOOTH_SEQ_UNSIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    booth_r4_seq_mult_ctrl #(.WIDTH(W4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .in_ready  (r4),
        .in_a      (a4),
        .in_b      (b4),
`ifdef BOOTH_SEQ_UNSIGNED_EN
        .in_signed (1'b1),
`endif
        .out_valid (ov4),
        .out_ready (or4),
        .out_p     (p4),
        .busy      (busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input bit s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 16'(ia * ib);
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] a,
                                        input logic [3:0] b);
        return 8'(int'($signed(a)) * int'($signed(b)));
    endfunction

    function automatic int exp_lat(input bit s);
`ifdef BOOTH_SEQ_UNSIGNED_EN
        return s ? NDIG + 1 : NDIG + 2;
`else
        return s ? NDIG + 1 : NDIG + 1;
`endif
    endfunction

    // Starts and ends on a falling edge; latency counted in cycles
    // from the accepting cycle to the first cycle with out_valid.
    task automatic do_txn(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input bit s);
        int n;
        int lat;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, "_acc_timeout"}, 32'(n), 32'(0));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(s)));
        chk({tag, "_p"}, 32'(out_p), 32'(ref8(a, b, s)));
        @(negedge clk);
        chk({tag, "_drop"}, 32'(out_valid), 32'(0));
    endtask

    initial begin
        int n;
        int cyc;
        int seen;
        int acc_n;
        int chk_n;
        int last_acc;
        int idx;
        logic [15:0] q[$];
        logic [7:0]  q4[$];
        logic [15:0] e16;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b1;
        out_ready = 1'b1;
        v4        = 1'b0;
        a4        = '0;
        b4        = '0;
        or4       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_p", 32'(out_p), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a RUN discards the operation.
        in_a     = 8'd5;
        in_b     = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_p", 32'(out_p), 32'(0));
        chk("mid_rst_ready", 32'(in_ready), 32'(1));
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst_no_out", 32'(seen), 32'(0));

        // Corner products.
        do_txn("c_m128_m128", 8'h80, 8'h80, 1'b1);
        do_txn("c_127_m128", 8'h7F, 8'h80, 1'b1);
        do_txn("c_0_m77", 8'h00, 8'hB3, 1'b1);
        do_txn("c_m1_m1", 8'hFF, 8'hFF, 1'b1);
        chk("c_const_4000", 32'(ref8(8'h80, 8'h80, 1'b1)), 32'h4000);
        repeat (6) do_txn("rnd", 8'($urandom), 8'($urandom), 1'b1);

        // Backpressure: product held while out_ready is low.
        in_a      = 8'd7;
        in_b      = 8'hFA;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_a = 8'd99;
        in_b = 8'd99;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_arrive", 32'(out_valid), 32'(1));
        repeat (10) begin
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_p", 32'(out_p), 32'hFFD6);
            chk("bp_ready", 32'(in_ready), 32'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'(0));
        chk("bp_release_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        chk("bp_single", 32'(out_valid), 32'(0));

        // Streaming with in_valid held high.
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        in_signed = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc_n     = 0;
        chk_n     = 0;
        last_acc  = -1;
        cyc       = 0;
        while (chk_n < 20 && cyc < 400) begin
            if (acc_n >= 20) in_valid = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("st_spurious", 32'(out_valid), 32'(0));
                end else begin
                    e16 = q.pop_front();
                    chk("st_p", 32'(out_p), 32'(e16));
                end
                chk_n++;
            end
            if (in_valid && in_ready) begin
                if (last_acc >= 0) chk("st_gap", 32'(cyc - last_acc), 32'(6));
                last_acc = cyc;
                q.push_back(ref8(in_a, in_b, 1'b1));
                acc_n++;
            end else if (!in_ready) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("st_count", 32'(chk_n), 32'(20));
        chk("st_accepts", 32'(acc_n), 32'(20));

`ifdef BOOTH_SEQ_UNSIGNED_EN
        do_txn("u_255_255", 8'hFF, 8'hFF, 1'b0);
        do_txn("s_255_255", 8'hFF, 8'hFF, 1'b1);
        repeat (6) do_txn("u_rnd", 8'($urandom), 8'($urandom), 1'b0);
`endif

        // Exhaustive WIDTH=4, back to back.
        idx   = 0;
        chk_n = 0;
        cyc   = 0;
        a4    = 4'(idx >> 4);
        b4    = 4'(idx);
        v4    = 1'b1;
        while (chk_n < 256 && cyc < 3000) begin
            if (idx >= 256) v4 = 1'b0;
            if (ov4) begin
                if (q4.size() == 0) begin
                    chk("ex_spurious", 32'(ov4), 32'(0));
                end else begin
                    chk("ex_p", 32'(p4), 32'(q4.pop_front()));
                end
                chk_n++;
            end
            if (v4 && r4) begin
                q4.push_back(ref4(a4, b4));
                idx++;
            end else if (!r4 && idx < 256) begin
                a4 = 4'(idx >> 4);
                b4 = 4'(idx);
            end
            @(negedge clk);
            cyc++;
        end
        v4 = 1'b0;
        chk("ex_count", 32'(chk_n), 32'(256));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
